// File: rtl/scaler_read_ctrl.sv
// Read-side sequencer for a fixed-point scaler: walks hAcc/vAcc over a shared line buffer.
// Optional stall counter output enabled by defining SCALER_READ_CTRL_STALL_CNT_EN.
module scaler_read_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FRAC_WIDTH    = 8,
  parameter int BUFFER_LINES  = 3
) (
  input  logic                            clk_fast,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] hStep,
  input  logic [FRAC_WIDTH:0]             vStep,
  input  logic [11:0]                     outWidth,
  input  logic [11:0]                     outHeight,
  input  logic [11:0]                     fillCount,
  input  logic                            outReady,
  output logic [ADDRESS_WIDTH-1:0]        readAddress,
  output logic [FRAC_WIDTH-1:0]           hFrac,
  output logic [FRAC_WIDTH-1:0]           vFrac,
  output logic                            pixelValid,
  output logic                            advanceRead1,
  output logic                            advanceRead2,
  output logic                            forceRead,
  output logic                            busy,
`ifdef SCALER_READ_CTRL_STALL_CNT_EN
  output logic [15:0]                     stallCount,
`endif
  output logic                            frameDone
);

  localparam int HW = ADDRESS_WIDTH + FRAC_WIDTH;
  localparam logic [11:0] LP_FULL = 12'(BUFFER_LINES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_FILL, S_LINE, S_ADVANCE, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [HW-1:0]         r_hstep, r_hacc;
  logic [FRAC_WIDTH:0]   r_vstep;
  logic [FRAC_WIDTH-1:0] r_vacc;
  logic [11:0]           r_width, r_height, r_xcount, r_ycount;
  logic [1:0]            r_carry;
  logic                  r_force_read;

  logic                  w_fill_ok, w_last_pix, w_last_line, w_zero_dim;
  logic [FRAC_WIDTH+1:0] w_vsum;

  assign w_fill_ok   = fillCount >= 12'd2;
  assign w_last_pix  = r_xcount == (r_width - 12'd1);
  assign w_last_line = r_ycount == (r_height - 12'd1);
  assign w_zero_dim  = (outWidth == 12'd0) || (outHeight == 12'd0);
  // vAcc frac + vStep never exceeds 3.0, so two integer bits hold the carry
  assign w_vsum      = {2'b00, r_vacc} + {1'b0, r_vstep};

  always_ff @(posedge clk_fast) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_next = w_zero_dim ? S_DONE : S_WAIT_FILL;
      S_WAIT_FILL: if (w_fill_ok) w_state_next = S_LINE;
      S_LINE:      if (outReady && w_last_pix) w_state_next = S_ADVANCE;
      S_ADVANCE:   w_state_next = w_last_line ? S_DONE : S_WAIT_FILL;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pixelValid   = (r_state == S_LINE);
    advanceRead1 = (r_state == S_ADVANCE) && (r_carry == 2'd1);
    advanceRead2 = (r_state == S_ADVANCE) && (r_carry == 2'd2);
    busy         = (r_state != S_IDLE);
    frameDone    = (r_state == S_DONE);
    readAddress  = r_hacc[HW-1:FRAC_WIDTH];
    hFrac        = r_hacc[FRAC_WIDTH-1:0];
    vFrac        = r_vacc;
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_hstep  <= '0;
      r_vstep  <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_hacc   <= '0;
      r_vacc   <= '0;
      r_xcount <= '0;
      r_ycount <= '0;
      r_carry  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_hstep  <= hStep;
          r_vstep  <= vStep;
          r_width  <= outWidth;
          r_height <= outHeight;
          r_vacc   <= '0;
          r_xcount <= '0;
          r_ycount <= '0;
        end
        S_WAIT_FILL: r_hacc <= '0;
        S_LINE: if (outReady) begin
          // integer part wraps naturally at the accumulator width
          r_hacc   <= r_hacc + r_hstep;
          r_xcount <= r_xcount + 12'd1;
          if (w_last_pix) r_carry <= w_vsum[FRAC_WIDTH+1:FRAC_WIDTH];
        end
        S_ADVANCE: begin
          r_vacc   <= w_vsum[FRAC_WIDTH-1:0];
          r_xcount <= '0;
          if (!w_last_line) r_ycount <= r_ycount + 12'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst) r_force_read <= 1'b0;
    else     r_force_read <= fillCount >= LP_FULL;
  end
  assign forceRead = r_force_read;

`ifdef SCALER_READ_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  // counts WAIT_FILL cycles that could not proceed for lack of buffered lines
  always_ff @(posedge clk_fast) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_state == S_IDLE && start)
      r_stall_cnt <= '0;
    else if (r_state == S_WAIT_FILL && !w_fill_ok && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_scaler_read_ctrl.sv
// Self-checking bench for scaler_read_ctrl: frame table plus pixel/carry scoreboard.
// Define SCALER_READ_CTRL_STALL_CNT_EN to also check the stall counter.
module tb_scaler_read_ctrl;

  logic        clk_fast = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hStep = '0;
  logic [8:0]  vStep = '0;
  logic [11:0] outWidth = '0, outHeight = '0, fillCount = '0;
  logic        outReady = 1'b0;
  logic [7:0]  readAddress, hFrac, vFrac;
  logic        pixelValid, advanceRead1, advanceRead2, forceRead, busy, frameDone;
`ifdef SCALER_READ_CTRL_STALL_CNT_EN
  logic [15:0] stallCount;
`endif

  scaler_read_ctrl dut (
    .clk_fast(clk_fast), .rst(rst), .start(start), .hStep(hStep), .vStep(vStep),
    .outWidth(outWidth), .outHeight(outHeight), .fillCount(fillCount), .outReady(outReady),
    .readAddress(readAddress), .hFrac(hFrac), .vFrac(vFrac), .pixelValid(pixelValid),
    .advanceRead1(advanceRead1), .advanceRead2(advanceRead2), .forceRead(forceRead),
    .busy(busy),
`ifdef SCALER_READ_CTRL_STALL_CNT_EN
    .stallCount(stallCount),
`endif
    .frameDone(frameDone)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct {
    logic [15:0] hstep;
    logic [8:0]  vstep;
    logic [11:0] w, h;
    int          stall;
    int          ready_mode;
    bit          poke;
    int          n_adv1, n_adv2;
    logic [31:0] addr4, frac4;
  } vec_t;

  typedef struct {
    logic [7:0] addr, hf, vf;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_carry[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_model(input vec_t v);
    int vacc, tot, acc;
    pix_t p;
    exp_pix.delete();
    exp_carry.delete();
    vacc = 0;
    if (v.w == 0 || v.h == 0) return;
    for (int y = 0; y < int'(v.h); y++) begin
      for (int x = 0; x < int'(v.w); x++) begin
        acc = x * int'(v.hstep);
        p.addr = 8'((acc >> 8) & 255);
        p.hf = 8'(acc & 255);
        p.vf = 8'(vacc);
        exp_pix.push_back(p);
      end
      tot = vacc + int'(v.vstep);
      vacc = tot & 255;
      if ((tot >> 8) != 0) exp_carry.push_back(tot >> 8);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    bit done, poked, saw_valid, hold_pend;
    logic [7:0] hold_a, hold_f;
    int nacc, n1, n2, nfirst;
    pix_t p;
    done = 0; poked = 0; saw_valid = 0; hold_pend = 0;
    nacc = 0; n1 = 0; n2 = 0;
    hold_a = '0; hold_f = '0;
    nfirst = (v.h == 0) ? 0 : ((int'(v.w) < 4) ? int'(v.w) : 4);
    build_model(v);
    @(posedge clk_fast); #1;
    hStep = v.hstep; vStep = v.vstep; outWidth = v.w; outHeight = v.h;
    fillCount = 12'd2; outReady = 1'b1; start = 1'b1;
    @(posedge clk_fast); #1;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      fillCount = (cyc < v.stall) ? 12'd1 : 12'd2;
      outReady = (v.ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (v.poke && !poked && saw_valid) begin
        start = 1'b1; hStep = 16'hFFFF; outWidth = 12'd1; outHeight = 12'd1;
        poked = 1;
      end else begin
        start = 1'b0; hStep = v.hstep; outWidth = v.w; outHeight = v.h;
      end
      #1;
      if (cyc < v.stall) begin
        chk("stall_busy", {31'b0, busy}, 32'd1);
        chk("stall_pixelValid", {31'b0, pixelValid}, 32'd0);
      end
      if (hold_pend) begin
        chk("hold_valid", {31'b0, pixelValid}, 32'd1);
        chk("hold_addr", {24'b0, readAddress}, {24'b0, hold_a});
        chk("hold_hfrac", {24'b0, hFrac}, {24'b0, hold_f});
      end
      hold_pend = pixelValid && !outReady;
      hold_a = readAddress;
      hold_f = hFrac;
      saw_valid = saw_valid | pixelValid;
      if (pixelValid && outReady) begin
        if (exp_pix.size() == 0) begin
          chk("extra_pixel", 32'd1, 32'd0);
        end else begin
          p = exp_pix.pop_front();
          chk("pix_addr", {24'b0, readAddress}, {24'b0, p.addr});
          chk("pix_hfrac", {24'b0, hFrac}, {24'b0, p.hf});
          chk("pix_vfrac", {24'b0, vFrac}, {24'b0, p.vf});
        end
        if (nacc < nfirst) begin
          chk("tbl_addr", {24'b0, readAddress}, {24'b0, v.addr4[8*nacc +: 8]});
          chk("tbl_hfrac", {24'b0, hFrac}, {24'b0, v.frac4[8*nacc +: 8]});
        end
        nacc++;
      end
      if (advanceRead1 || advanceRead2) begin
        chk("adv_exclusive", {31'b0, advanceRead1 && advanceRead2}, 32'd0);
        if (advanceRead1) n1++;
        if (advanceRead2) n2++;
        if (exp_carry.size() == 0) chk("extra_advance", 32'd1, 32'd0);
        else chk("adv_carry", advanceRead1 ? 32'd1 : 32'd2, 32'(exp_carry.pop_front()));
      end
      if (frameDone) begin
        done = 1;
        chk("done_pixels_left", 32'(exp_pix.size()), 32'd0);
        chk("done_carries_left", 32'(exp_carry.size()), 32'd0);
        chk("tbl_adv1", 32'(n1), 32'(v.n_adv1));
        chk("tbl_adv2", 32'(n2), 32'(v.n_adv2));
        if (v.w == 0 || v.h == 0) chk("zero_dim_done_cycle", 32'(cyc), 32'd0);
      end
      if (!done) begin
        @(posedge clk_fast); #1;
      end
    end
    if (!done) chk("frame_timeout", 32'd0, 32'd1);
    start = 1'b0; hStep = v.hstep; outWidth = v.w; outHeight = v.h;
`ifdef SCALER_READ_CTRL_STALL_CNT_EN
    chk("stallCount", {16'b0, stallCount}, 32'(v.stall));
`endif
    @(posedge clk_fast); #1;
    chk("post_done_busy", {31'b0, busy}, 32'd0);
    chk("post_done_frameDone", {31'b0, frameDone}, 32'd0);
    $display("frame %0d: hStep=%0h vStep=%0h %0dx%0d pixels=%0d adv1=%0d adv2=%0d",
             idx, v.hstep, v.vstep, v.w, v.h, nacc, n1, n2);
  endtask

  vec_t vecs[10];
  int   evts;
  bit   seen;

  initial begin
    vecs[0] = '{hstep:16'h0100, vstep:9'h100, w:12'd4, h:12'd2, stall:0, ready_mode:0, poke:0,
                n_adv1:2, n_adv2:0, addr4:32'h03020100, frac4:32'h00000000};
    vecs[1] = '{hstep:16'h0080, vstep:9'h080, w:12'd4, h:12'd4, stall:0, ready_mode:0, poke:0,
                n_adv1:2, n_adv2:0, addr4:32'h01010000, frac4:32'h80008000};
    vecs[2] = '{hstep:16'h0100, vstep:9'h1C0, w:12'd4, h:12'd4, stall:0, ready_mode:0, poke:0,
                n_adv1:1, n_adv2:3, addr4:32'h03020100, frac4:32'h00000000};
    vecs[3] = '{hstep:16'h0100, vstep:9'h100, w:12'd4, h:12'd1, stall:10, ready_mode:0, poke:0,
                n_adv1:1, n_adv2:0, addr4:32'h03020100, frac4:32'h00000000};
    vecs[4] = '{hstep:16'h0180, vstep:9'h100, w:12'd5, h:12'd2, stall:0, ready_mode:1, poke:0,
                n_adv1:2, n_adv2:0, addr4:32'h04030100, frac4:32'h80008000};
    vecs[5] = '{hstep:16'h00C0, vstep:9'h0C0, w:12'd4, h:12'd3, stall:0, ready_mode:0, poke:1,
                n_adv1:2, n_adv2:0, addr4:32'h02010000, frac4:32'h4080C000};
    vecs[6] = '{hstep:16'h0100, vstep:9'h100, w:12'd4, h:12'd0, stall:0, ready_mode:0, poke:0,
                n_adv1:0, n_adv2:0, addr4:32'h0, frac4:32'h0};
    vecs[7] = '{hstep:16'h0100, vstep:9'h100, w:12'd0, h:12'd3, stall:0, ready_mode:0, poke:0,
                n_adv1:0, n_adv2:0, addr4:32'h0, frac4:32'h0};
    vecs[8] = '{hstep:16'h4000, vstep:9'h100, w:12'd6, h:12'd1, stall:0, ready_mode:0, poke:0,
                n_adv1:1, n_adv2:0, addr4:32'hC0804000, frac4:32'h00000000};
    vecs[9] = '{hstep:16'h0100, vstep:9'h1FF, w:12'd2, h:12'd3, stall:0, ready_mode:1, poke:0,
                n_adv1:1, n_adv2:2, addr4:32'h00000100, frac4:32'h00000000};

    // reset must dominate even with a full buffer reported
    rst = 1'b1; fillCount = 12'd3;
    repeat (3) @(posedge clk_fast);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_pixelValid", {31'b0, pixelValid}, 32'd0);
    chk("rst_forceRead", {31'b0, forceRead}, 32'd0);
    chk("rst_frameDone", {31'b0, frameDone}, 32'd0);
    chk("rst_adv", {30'b0, advanceRead1, advanceRead2}, 32'd0);
    chk("rst_addr_fracs", {8'b0, readAddress, hFrac, vFrac}, 32'd0);
    rst = 1'b0; fillCount = 12'd2;
    @(posedge clk_fast); #1;

    // forceRead is registered: visible one cycle after fillCount reaches BUFFER_LINES
    fillCount = 12'd3; #1;
    chk("forceRead_before_edge", {31'b0, forceRead}, 32'd0);
    @(posedge clk_fast); #1;
    chk("forceRead_set", {31'b0, forceRead}, 32'd1);
    fillCount = 12'd2;
    @(posedge clk_fast); #1;
    chk("forceRead_clear", {31'b0, forceRead}, 32'd0);

    for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

    // reset mid-line aborts the frame silently
    @(posedge clk_fast); #1;
    hStep = 16'h0100; vStep = 9'h100; outWidth = 12'd8; outHeight = 12'd4;
    fillCount = 12'd2; outReady = 1'b1; start = 1'b1;
    @(posedge clk_fast); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (pixelValid) seen = 1;
      else begin
        @(posedge clk_fast); #1;
      end
    end
    chk("midrst_reached_line", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    @(posedge clk_fast); #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_pixelValid", {31'b0, pixelValid}, 32'd0);
    chk("midrst_addr_fracs", {8'b0, readAddress, hFrac, vFrac}, 32'd0);
    chk("midrst_flags", {28'b0, advanceRead1, advanceRead2, frameDone, forceRead}, 32'd0);
    rst = 1'b0;
    evts = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_fast); #1;
      if (frameDone || advanceRead1 || advanceRead2 || busy) evts++;
    end
    chk("midrst_no_events", 32'(evts), 32'd0);
    $display("reset mid-frame: events after abort=%0d", evts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
